// File: rtl/capture_controller.sv
// capture_controller: triggered frame capture of one ADC channel into a circular sample RAM
module capture_controller #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 10,
  parameter int ADDR_W = 10,
  parameter int AUTO_TIMEOUT = 1000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_sample_valid,
  input  logic [WIDTH-1:0]  i_sample,
  input  logic [WIDTH-1:0]  i_level,
  input  logic              i_edge,
  input  logic [1:0]        i_mode,
  input  logic              i_arm,
  input  logic [ADDR_W-1:0] i_pretrig,
  input  logic              i_frame_ack,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [WIDTH-1:0]  o_wr_data,
  output logic [ADDR_W-1:0] o_frame_base,
  output logic              o_frame_ready,
  output logic              o_triggered,
  output logic [2:0]        o_state
);
  typedef enum logic [2:0] {IDLE, PREFILL, ARMED, POST, HOLD} state_t;
  localparam int AW = $clog2(AUTO_TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0] DEP = (ADDR_W + 1)'(DEPTH);
  localparam logic [AW-1:0] TMO = AW'(AUTO_TIMEOUT - 1);
  state_t state;
  logic [ADDR_W-1:0] ptr, pre, cnt, trig_addr, nxt_ptr, pre_in, t;
  logic [ADDR_W:0] base_x;
  logic [1:0] mode;
  logic [WIDTH-1:0] prev;
  logic prev_ok, wr, go_pre, real_trig, hit;
  logic [AW-1:0] acnt;
  assign o_state = state;
  always_comb begin
    wr = i_sample_valid && (state == ARMED || state == POST || (state == PREFILL && cnt != pre));
    nxt_ptr = (ptr == LAST) ? '0 : ptr + ADDR_W'(1);
    pre_in = (i_pretrig > LAST) ? LAST : i_pretrig;
    go_pre = (state == IDLE && (i_mode != 2'b10 || i_arm)) || (state == HOLD && i_frame_ack && mode != 2'b10);
    real_trig = prev_ok && (i_edge ? (prev > i_level && i_sample <= i_level)
                                   : (prev < i_level && i_sample >= i_level));
    hit = state == ARMED && i_sample_valid && (real_trig || (mode == 2'b00 && acnt == TMO));
    t = (state == ARMED) ? ptr : trig_addr;
    base_x = {1'b0, t} + ((t < pre) ? DEP : '0) - {1'b0, pre};
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      ptr <= '0;
      pre <= '0;
      cnt <= '0;
      trig_addr <= '0;
      mode <= '0;
      prev <= '0;
      prev_ok <= 1'b0;
      acnt <= '0;
      o_wr_en <= 1'b0;
      o_wr_addr <= '0;
      o_wr_data <= '0;
      o_frame_base <= '0;
      o_frame_ready <= 1'b0;
      o_triggered <= 1'b0;
    end else begin
      o_wr_en <= wr;
      if (wr) begin
        o_wr_addr <= ptr;
        o_wr_data <= i_sample;
        ptr <= nxt_ptr;
        prev <= i_sample;
        prev_ok <= 1'b1;
      end
      if (go_pre) begin
        state <= PREFILL;
        pre <= pre_in;
        mode <= i_mode;
        cnt <= '0;
        acnt <= '0;
        prev_ok <= 1'b0;
        o_frame_ready <= 1'b0;
      end else begin
        case (state)
          PREFILL: begin
            if (cnt == pre) state <= ARMED;
            else if (wr) begin
              cnt <= cnt + ADDR_W'(1);
              if (cnt + ADDR_W'(1) == pre) state <= ARMED;
            end
          end
          ARMED: begin
            if (i_sample_valid) acnt <= acnt + AW'(1);
            if (hit) begin
              trig_addr <= ptr;
              o_triggered <= real_trig;
              cnt <= '0;
              state <= (pre == LAST) ? HOLD : POST;
              if (pre == LAST) begin
                o_frame_ready <= 1'b1;
                o_frame_base <= base_x[ADDR_W-1:0];
              end
            end
          end
          POST: begin
            if (wr) begin
              cnt <= cnt + ADDR_W'(1);
              if (cnt == LAST - pre - ADDR_W'(1)) begin
                state <= HOLD;
                o_frame_ready <= 1'b1;
                o_frame_base <= base_x[ADDR_W-1:0];
              end
            end
          end
          HOLD: begin
            if (i_frame_ack) begin
              state <= IDLE;
              o_frame_ready <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_capture_controller.sv
// tb_capture_controller: scoreboard bench for capture_controller write stream and frame results
module tb_capture_controller;
  localparam int DEPTH = 640;
  typedef struct packed {logic [9:0] a; logic [9:0] d;} wr_t;
  typedef struct packed {logic [9:0] b; logic t;} fr_t;
  logic clk = 0, rst = 1, sv = 0, edge_sel = 0, arm = 0, ack = 0;
  logic [9:0] smp = 0, level = 10'd512, pretrig = 0;
  logic [1:0] mode = 2'b10;
  logic o_wr_en, o_frame_ready, o_triggered;
  logic [9:0] o_wr_addr, o_wr_data, o_frame_base;
  logic [2:0] o_state;
  int tests = 0, fails = 0, mptr = 0;
  wr_t wq[$];
  fr_t fq[$];
  logic prev_fr = 0;
  wr_t e;
  fr_t f;

  capture_controller dut (
    .i_clk(clk), .i_rst(rst), .i_sample_valid(sv), .i_sample(smp), .i_level(level),
    .i_edge(edge_sel), .i_mode(mode), .i_arm(arm), .i_pretrig(pretrig), .i_frame_ack(ack),
    .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data), .o_frame_base(o_frame_base),
    .o_frame_ready(o_frame_ready), .o_triggered(o_triggered), .o_state(o_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) prev_fr = 0;
    else begin
      if (o_wr_en) begin
        if (wq.size() == 0) check("unexpected write", 1, 0);
        else begin
          e = wq.pop_front();
          check("wr_addr", o_wr_addr, e.a);
          check("wr_data", o_wr_data, e.d);
        end
      end
      if (o_frame_ready && !prev_fr) begin
        if (fq.size() == 0) check("unexpected frame", 1, 0);
        else begin
          f = fq.pop_front();
          check("frame_base", o_frame_base, f.b);
          check("triggered", o_triggered, f.t);
          check("pending writes at frame", wq.size(), 0);
        end
      end
      prev_fr = o_frame_ready;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick;
  endtask

  task automatic send(input logic [9:0] v, input bit w);
    wr_t x;
    sv = 1;
    smp = v;
    if (w) begin
      x.a = 10'(mptr);
      x.d = v;
      wq.push_back(x);
      mptr = (mptr + 1) % DEPTH;
    end
    tick;
    sv = 0;
    tick;
  endtask

  task automatic sendn(input int n, input logic [9:0] v);
    for (int i = 0; i < n; i++) send(v, 1);
  endtask

  task automatic exp_frame(input int b, input bit t);
    fr_t x;
    x.b = 10'(b);
    x.t = t;
    fq.push_back(x);
  endtask

  task automatic wait_state(input logic [2:0] s, input string name);
    for (int i = 0; i < 64 && o_state !== s; i++) tick;
    check(name, o_state, s);
  endtask

  task automatic pulse_ack;
    ack = 1;
    tick;
    ack = 0;
    tick;
  endtask

  task automatic check_reset(input string tag);
    check({tag, " state"}, o_state, 0);
    check({tag, " wr_en"}, o_wr_en, 0);
    check({tag, " wr_addr"}, o_wr_addr, 0);
    check({tag, " wr_data"}, o_wr_data, 0);
    check({tag, " frame_base"}, o_frame_base, 0);
    check({tag, " frame_ready"}, o_frame_ready, 0);
    check({tag, " triggered"}, o_triggered, 0);
  endtask

  initial begin
    repeat (100000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle(3);
    check_reset("reset");
    rst = 0;
    // single mode without arm: nothing happens, samples are dropped
    idle(5);
    check("single idle state", o_state, 0);
    check("single idle wr_en", o_wr_en, 0);
    send(10'd100, 0);
    check("single idle after sample", o_state, 0);
    // single capture: pre=200, trigger at address 400 -> base 200
    pretrig = 200;
    exp_frame(200, 1);
    arm = 1;
    tick;
    arm = 0;
    idle(3);
    check("prefill state", o_state, 1);
    sendn(200, 10'd100);
    check("armed state", o_state, 2);
    sendn(200, 10'd100);
    send(10'd600, 1);
    check("post state", o_state, 3);
    sendn(439, 10'd100);
    wait_state(4, "single hold");
    check("single frame_ready", o_frame_ready, 1);
    send(10'd600, 0);
    arm = 1;
    tick;
    arm = 0;
    pulse_ack;
    check("single back to idle", o_state, 0);
    check("single ready cleared", o_frame_ready, 0);
    send(10'd100, 0);
    send(10'd600, 0);
    idle(5);
    check("single no rearm", o_state, 0);
    // normal, pre=100, ramp crossing 512 at address 300 -> base 200
    mode = 2'b01;
    pretrig = 100;
    exp_frame(200, 1);
    idle(3);
    for (int i = 0; i < 100; i++) send(10'(i * 5), 1);
    send(10'd512, 1);
    sendn(539, 10'd7);
    wait_state(4, "normal hold");
    // falling edge: 600 (rising, ignored) then 512 triggers at 203 -> base 201
    edge_sel = 1;
    pretrig = 2;
    exp_frame(201, 1);
    pulse_ack;
    idle(3);
    send(10'd300, 1);
    send(10'd300, 1);
    send(10'd600, 1);
    check("falling ignores rising", o_state, 2);
    send(10'd512, 1);
    check("falling trigger", o_state, 3);
    send(10'd400, 1);
    sendn(636, 10'd600);
    wait_state(4, "falling hold");
    // pre=700 clamps to 639: trigger at 200 goes straight to HOLD, base 201
    edge_sel = 0;
    pretrig = 700;
    exp_frame(201, 1);
    pulse_ack;
    idle(3);
    sendn(639, 10'd0);
    check("clamp armed", o_state, 2);
    send(10'd600, 1);
    check("clamp direct hold", o_state, 4);
    check("clamp frame_ready", o_frame_ready, 1);
    // base wrap: trigger at 50 with pre=100 -> 590
    pretrig = 100;
    exp_frame(590, 1);
    pulse_ack;
    idle(3);
    sendn(489, 10'd0);
    send(10'd600, 1);
    sendn(539, 10'd0);
    wait_state(4, "wrap hold");
    // reset in POST abandons the frame
    pretrig = 10;
    pulse_ack;
    idle(3);
    sendn(10, 10'd0);
    send(10'd600, 1);
    sendn(5, 10'd0);
    check("post before reset", o_state, 3);
    rst = 1;
    tick;
    check_reset("mid reset");
    mptr = 0;
    mode = 2'b01;
    pretrig = 100;
    rst = 0;
    exp_frame(0, 1);
    idle(3);
    sendn(100, 10'd0);
    send(10'd600, 1);
    sendn(539, 10'd0);
    wait_state(4, "after reset hold");
    // auto mode, constant 100: 1000th armed sample at 359 forces the frame
    mode = 2'b00;
    pretrig = 0;
    pulse_ack;
    idle(3);
    check("auto armed", o_state, 2);
    exp_frame(359, 0);
    sendn(999, 10'd100);
    check("auto still armed", o_state, 2);
    send(10'd100, 1);
    check("auto timeout post", o_state, 3);
    sendn(639, 10'd100);
    wait_state(4, "auto hold");
    check("auto triggered", o_triggered, 0);
    idle(2);
    check("writes drained", wq.size(), 0);
    check("frames drained", fq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/capture_controller.md
Name: capture_controller

Overview:
- Sequences acquisition of one ADC channel into a DEPTH-entry circular sample RAM, replacing the free-running shift-register capture with triggered frames.
- Detects a level crossing at a programmable trigger level and edge, keeps a programmable pre-trigger history, and freezes a complete frame for the VGA renderer.
- Sits between the ADC sample stream and the sample RAM / Color_AnalogSignal read path.

Parameters:
- DEPTH, 640: frame length in samples (one per screen column).
- WIDTH, 10: sample width in bits.
- ADDR_W, 10: RAM address width; 2**ADDR_W >= DEPTH.
- AUTO_TIMEOUT, 1000: samples spent in ARMED before auto mode forces a frame.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  synchronous, active-high reset.
- i_sample_valid  in  1  one-cycle strobe per new ADC sample.
- i_sample  in  WIDTH  ADC sample, qualified by i_sample_valid.
- i_level  in  WIDTH  trigger level.
- i_edge  in  1  0 = rising, 1 = falling.
- i_mode  in  2  00 = auto, 01 = normal, 10 = single, 11 = normal.
- i_arm  in  1  single-mode arm pulse.
- i_pretrig  in  ADDR_W  pre-trigger sample count.
- i_frame_ack  in  1  renderer has consumed the frozen frame.
- o_wr_en  out  1  RAM write enable.
- o_wr_addr  out  ADDR_W  RAM write address.
- o_wr_data  out  WIDTH  RAM write data.
- o_frame_base  out  ADDR_W  RAM address of the oldest sample in the frozen frame.
- o_frame_ready  out  1  frozen frame is valid.
- o_triggered  out  1  1 = frame from a real trigger, 0 = from auto timeout.
- o_state  out  3  current state encoding.

Behaviour:
- Clock and reset: i_clk only; i_rst is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; write pointer 0; prev-valid flag cleared. A reset mid-capture abandons the frame with no partial o_frame_ready.
- State encodings: IDLE=0, PREFILL=1, ARMED=2, POST=3, HOLD=4.
- Writing states are PREFILL, ARMED and POST. A valid sample in cycle N gives, in cycle N+1: o_wr_en=1, o_wr_data=sample, o_wr_addr=pointer. The pointer then increments and wraps DEPTH-1 -> 0. o_wr_en is 0 in every other cycle and state.
- Latch point: on any entry to PREFILL, latch pre = min(i_pretrig, DEPTH-1) and the mode. Changes during a capture are ignored. Also clear the pre-count and the prev-valid flag.
- IDLE: in non-single mode (live i_mode), go to PREFILL next cycle. In single mode, wait for i_arm=1, then go to PREFILL. i_arm outside IDLE is ignored.
- PREFILL: count written samples. When count == pre, go to ARMED; pre=0 reaches ARMED on the next cycle.
- ARMED: write samples.
  - Rising trigger: prev < level and cur >= level.
  - Falling trigger: prev > level and cur <= level.
  - Comparisons are unsigned. No trigger while prev-valid=0 (first sample after PREFILL entry).
  - On a trigger, record trig_addr (address of the triggering sample) and set o_triggered=1.
  - In auto mode, count valid samples in ARMED. When the AUTO_TIMEOUT-th sample arrives without a trigger, treat that sample as the trigger with o_triggered=0. A real crossing on the same sample wins (o_triggered=1).
  - Next state is POST, or HOLD directly if pre == DEPTH-1.
- POST: write DEPTH-1-pre further samples after the trigger sample, then go to HOLD. A frame is therefore pre + 1 + post = DEPTH samples.
- HOLD:
  - No writes; samples are dropped.
  - o_frame_ready=1.
  - o_frame_base = (trig_addr - pre) mod DEPTH, held stable through HOLD.
  - On i_frame_ack: o_frame_ready=0 next cycle. Go to IDLE if the latched mode is single, else PREFILL.
  - i_frame_ack outside HOLD is ignored.
- Outside HOLD, o_frame_base and o_triggered hold their last values.
- PREFILL guarantees history: PREFILL always rewrites at least pre samples before arming, so frame samples are never stale.

Test Plan:
- Normal mode, pre=100, rising ramp crossing level=512: trigger sample at pointer 300 -> o_frame_base=200. Exactly 640 writes from PREFILL entry to HOLD, o_triggered=1.
- Falling edge, level=512, samples 600, 512, 400: trigger on the 512 sample; a subsequent rising crossing in the same stream does not trigger.
- Auto mode, constant input 100, level=512, pre=0: HOLD reached after 1000 ARMED samples + 639 post samples, o_triggered=0.
- Single mode: with no i_arm, stays in IDLE with o_wr_en=0. After i_arm, captures one frame. After i_frame_ack, returns to IDLE; a second crossing produces no frame.
- Boundaries:
  - pre=700 clamps to 639: trigger goes straight to HOLD.
  - Pointer wraps 639 -> 0.
  - o_frame_base wraps: trig_addr=50, pre=100 gives 590.
- i_rst asserted in POST: next cycle all outputs 0, state IDLE. Then a full normal frame completes correctly.
